uc_multicanal: RTL and testbench

Parametrised control unit for the serial-command actuator subsystem. It drives N independent channels, where the original single-channel unit drove one lock/servo. It sits between the serial receiver (`fimRecepcao`, `comando`, `canal`) and the per-channel data registers and position actuators. Each received command either stores data into one channel's register or toggles that channel's open/closed position. Out-of-range channels are rejected, and an optional per-channel auto-close timeout is available.

---
 rtl/uc_multicanal.sv | 151 +++++++++++++++
 tb/tb_uc_multicanal.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uc_multicanal.sv
// uc_multicanal: multi-channel command decoder for the serial actuator subsystem.
// Each accepted serial word either pulses one channel's data-register enable or
// toggles that channel's open/closed position; channels >= N_CANAIS are rejected.
// Optional feature macro: UC_AUTO_FECHAR_EN (per-channel auto-close after
// TIMEOUT_CICLOS cycles open). Without it, positions change only by command or reset.
module uc_multicanal #(
  parameter int N_CANAIS       = 4,
  parameter int TIMEOUT_CICLOS = 1000,
  localparam int CW            = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fimRecepcao,
  input  logic                comando,
  input  logic [CW-1:0]       canal,
  output logic [N_CANAIS-1:0] abrir,
  output logic [N_CANAIS-1:0] enableReg,
  output logic                pronto,
  output logic                erroCanal,
  output logic                perdido,
  output logic [3:0]          dbEstado
);

  typedef enum logic [2:0] {
    s_inicial       = 3'd0,
    s_espera_dado   = 3'd1,
    s_decodifica    = 3'd2,
    s_armazena_dado = 3'd3,
    s_mudar_posicao = 3'd4,
    s_erro          = 3'd5
  } estado_t;

  // Channel count widened by one bit so N_CANAIS = 2**CW still fits.
  localparam logic [CW:0] NC = (CW+1)'(N_CANAIS);

  estado_t       state;
  estado_t       state_next;
  logic          comando_l;
  logic [CW-1:0] canal_l;
  logic          canal_ok;

  assign canal_ok = ({1'b0, canal_l} < NC);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= s_inicial;
    else        state <= state_next;
  end

  // Capture the command word only at the moment it is accepted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      comando_l <= 1'b0;
      canal_l   <= '0;
    end else if (state == s_espera_dado && fimRecepcao) begin
      comando_l <= comando;
      canal_l   <= canal;
    end
  end

  // Flag words that arrive while the unit is busy; they are simply discarded.
  always_ff @(posedge clock) begin
    if (!reset) perdido <= 1'b0;
    else        perdido <= fimRecepcao && (state != s_espera_dado);
  end

  // Next-state decode and per-state combinational outputs.
  always_comb begin
    state_next = state;
    enableReg  = '0;
    erroCanal  = 1'b0;
    pronto     = 1'b0;
    dbEstado   = 4'hF;
    case (state)
      s_inicial: begin
        dbEstado   = 4'd0;
        state_next = s_espera_dado;
      end
      s_espera_dado: begin
        dbEstado = 4'd1;
        pronto   = 1'b1;
        if (fimRecepcao) state_next = s_decodifica;
      end
      s_decodifica: begin
        dbEstado = 4'd2;
        if (!canal_ok)     state_next = s_erro;
        else if (comando_l) state_next = s_mudar_posicao;
        else                state_next = s_armazena_dado;
      end
      s_armazena_dado: begin
        dbEstado = 4'd3;
        for (int i = 0; i < N_CANAIS; i++)
          enableReg[i] = (canal_l == CW'(i));
        state_next = s_espera_dado;
      end
      s_mudar_posicao: begin
        dbEstado   = 4'd4;
        state_next = s_espera_dado;
      end
      s_erro: begin
        dbEstado   = 4'd5;
        erroCanal  = 1'b1;
        state_next = s_espera_dado;
      end
      default: begin
        dbEstado   = 4'hF;
        state_next = s_inicial;
      end
    endcase
  end

`ifdef UC_AUTO_FECHAR_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

  logic [TW-1:0] timer [N_CANAIS];

  // Position registers with auto-close; a toggle on the expiry edge takes priority.
  always_ff @(posedge clock) begin
    if (!reset) begin
      abrir <= '0;
      for (int i = 0; i < N_CANAIS; i++) timer[i] <= '0;
    end else begin
      for (int i = 0; i < N_CANAIS; i++) begin
        if (state == s_mudar_posicao && canal_l == CW'(i)) begin
          abrir[i] <= ~abrir[i];
          timer[i] <= abrir[i] ? '0 : TW'(TIMEOUT_CICLOS);
        end else if (abrir[i]) begin
          if (timer[i] == TW'(1)) begin
            abrir[i] <= 1'b0;
            timer[i] <= '0;
          end else begin
            timer[i] <= timer[i] - TW'(1);
          end
        end
      end
    end
  end
`else
  // Position registers: flipped only when leaving the toggle state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      abrir <= '0;
    end else begin
      for (int i = 0; i < N_CANAIS; i++)
        if (state == s_mudar_posicao && canal_l == CW'(i))
          abrir[i] <= ~abrir[i];
    end
  end
`endif

endmodule

// File: tb/tb_uc_multicanal.sv
// tb_uc_multicanal: scoreboard bench for uc_multicanal (3 channels, so channel 3
// is out of range). A command-level reference model predicts every cycle's outputs.
module tb_uc_multicanal;
  localparam int N  = 3;
  localparam int T  = 10;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          fimRecepcao;
  logic          comando;
  logic [CW-1:0] canal;
  logic [N-1:0]  abrir;
  logic [N-1:0]  enableReg;
  logic          pronto;
  logic          erroCanal;
  logic          perdido;
  logic [3:0]    dbEstado;

  uc_multicanal #(.N_CANAIS(N), .TIMEOUT_CICLOS(T)) dut (
    .clock(clock), .reset(reset), .fimRecepcao(fimRecepcao), .comando(comando),
    .canal(canal), .abrir(abrir), .enableReg(enableReg), .pronto(pronto),
    .erroCanal(erroCanal), .perdido(perdido), .dbEstado(dbEstado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] abrir;
    logic [N-1:0] en;
    logic         pronto;
    logic         erro;
    logic         perd;
    logic [3:0]   db;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  // Reference model: age = cycles since a command was accepted
  // (-2 = just reset, -1 = ready, 0 = decoding, 1 = executing).
  int           age = -2;
  int           m_op = 0;
  int           m_ch = 0;
  logic [N-1:0] m_abrir = '0;
  int           open_edge [N];
  int           edge_n = 0;

  task automatic model_edge(input logic r, input logic f, input logic c, input int ch);
    exp_t e;
    logic perd;
    edge_n++;
    perd = 1'b0;
    if (!r) begin
      age     = -2;
      m_abrir = '0;
    end else begin
      perd = f && (age != -1);
      for (int i = 0; i < N; i++) begin
        if (age == 1 && m_op == 1 && m_ch == i) begin
          if (m_abrir[i]) m_abrir[i] = 1'b0;
          else begin
            m_abrir[i]   = 1'b1;
            open_edge[i] = edge_n;
          end
        end
`ifdef UC_AUTO_FECHAR_EN
        else if (m_abrir[i] && edge_n == open_edge[i] + T) m_abrir[i] = 1'b0;
`endif
      end
      if (age == -2) age = -1;
      else if (age == -1) begin
        if (f) begin
          age  = 0;
          m_op = int'(c);
          m_ch = ch;
        end
      end else if (age == 0) age = 1;
      else age = -1;
    end
    e.abrir  = m_abrir;
    e.perd   = perd;
    e.pronto = (age == -1);
    e.erro   = (age == 1) && (m_ch >= N);
    e.en     = (age == 1 && m_op == 0 && m_ch < N) ? N'(1 << m_ch) : '0;
    if (age == -2)      e.db = 4'd0;
    else if (age == -1) e.db = 4'd1;
    else if (age == 0)  e.db = 4'd2;
    else if (m_ch >= N) e.db = 4'd5;
    else if (m_op == 1) e.db = 4'd4;
    else                e.db = 4'd3;
    e.cyc = edge_n;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic f, input logic c, input int ch);
    reset       = r;
    fimRecepcao = f;
    comando     = c;
    canal       = CW'(ch);
    @(posedge clock);
    model_edge(r, f, c, ch);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // Monitor: compare every presented cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("abrir",     e.cyc, 32'(abrir),     32'(e.abrir));
        chk("enableReg", e.cyc, 32'(enableReg), 32'(e.en));
        chk("pronto",    e.cyc, 32'(pronto),    32'(e.pronto));
        chk("erroCanal", e.cyc, 32'(erroCanal), 32'(e.erro));
        chk("perdido",   e.cyc, 32'(perdido),   32'(e.perd));
        chk("dbEstado",  e.cyc, 32'(dbEstado),  32'(e.db));
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) open_edge[i] = 0;
    reset = 1'b0; fimRecepcao = 1'b0; comando = 1'b0; canal = '0;
    // reset held for two edges, then idle
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    idle(3);
    // store to channel 2
    step(1'b1, 1'b1, 1'b0, 2); idle(4);
    // toggle channel 1 twice, pulses 4 cycles apart
    step(1'b1, 1'b1, 1'b1, 1); idle(3);
    step(1'b1, 1'b1, 1'b1, 1); idle(4);
    // out-of-range channel, both command types
    step(1'b1, 1'b1, 1'b0, 3); idle(3);
    step(1'b1, 1'b1, 1'b1, 3); idle(3);
    // back-to-back pulses: second one dropped
    step(1'b1, 1'b1, 1'b1, 2); step(1'b1, 1'b1, 1'b0, 0); idle(4);
    // reset in the middle of a toggle command
    step(1'b1, 1'b1, 1'b1, 0); step(1'b0, 1'b0, 1'b0, 0); idle(3);
    step(1'b1, 1'b1, 1'b1, 0); step(1'b1, 1'b0, 1'b0, 0); step(1'b0, 1'b0, 1'b0, 0); idle(3);
    // open channel 0 and let it sit past the timeout
    step(1'b0, 1'b0, 1'b0, 0); idle(2);
    step(1'b1, 1'b1, 1'b1, 0); idle(15);
    // reopen channel 0, then toggle it exactly on its expiry edge
    step(1'b0, 1'b0, 1'b0, 0); idle(2);
    step(1'b1, 1'b1, 1'b1, 0); idle(9);
    step(1'b1, 1'b1, 1'b1, 0); idle(15);
    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 40),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
    idle(3);
    @(negedge clock);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
